// File: rtl/combo_lock_pkg.sv
// Shared types and constants for the combination-lock FSM and its button encoder.
package combo_lock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTRY    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  localparam int SYM_W   = 2;
  localparam int NUM_BTN = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/combo_lock_fsm_btn_encoder.sv
// Turns the one-cycle button pulses into a symbol index plus valid/invalid flags.
module btn_encoder
  import combo_lock_pkg::*;
(
  input  logic [NUM_BTN-1:0] btn_pulse,
  output logic [SYM_W-1:0]   sym,
  output logic               sym_valid,
  output logic               sym_invalid
);

  logic [2:0] hot_cnt;

  always_comb begin
    hot_cnt = '0;
    sym     = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      if (btn_pulse[k]) begin
        hot_cnt = hot_cnt + 3'd1;
        sym     = SYM_W'(k);
      end
    end
  end

  assign sym_valid   = (hot_cnt == 3'd1);
  assign sym_invalid = (hot_cnt > 3'd1);

endmodule

// File: rtl/combo_lock_fsm.sv
// Combination lock: collects CODE_LEN button symbols, unlocks on a match, locks out
// after MAX_FAIL wrong entries. One shared down-counter times entry, unlock and lockout.
module combo_lock_fsm
  import combo_lock_pkg::*;
#(
  parameter int                    CODE_LEN       = 4,
  parameter logic [2*CODE_LEN-1:0] CODE           = 8'b11_10_01_00,
  parameter int                    MAX_FAIL       = 3,
  parameter int                    UNLOCK_CYCLES  = 50_000_000,
  parameter int                    LOCKOUT_CYCLES = 500_000_000,
  parameter int                    ENTRY_TIMEOUT  = 250_000_000
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_BTN-1:0] btn_pulse,
  output logic               unlocked,
  output logic               lockout,
  output logic               fail,
  output logic [2:0]         entry_cnt
);

  localparam int MAX_T = max3(UNLOCK_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT);
  localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int FW    = (MAX_FAIL > 0) ? $clog2(MAX_FAIL + 1) : 1;

  localparam logic [TW-1:0] T_ENTRY  = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
  localparam logic [2:0]    CNT_FULL = 3'(CODE_LEN);
  localparam logic [15:0]   CODE_EXT = 16'(CODE);

  logic [SYM_W-1:0] sym;
  logic             sym_valid;
  logic             sym_invalid;

  btn_encoder u_enc (
    .btn_pulse  (btn_pulse),
    .sym        (sym),
    .sym_valid  (sym_valid),
    .sym_invalid(sym_invalid)
  );

  logic [SYM_W-1:0] code_tab [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_code
      assign code_tab[gi] = CODE_EXT[gi*SYM_W +: SYM_W];
    end
  endgenerate

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [FW-1:0] fail_cnt_reg;
  logic [2:0]    entry_cnt_reg;
  logic          mism_reg;
  logic          unlocked_reg;
  logic          lockout_reg;
  logic          fail_reg;

  logic          sym_any;
  logic          sym_diff;
  logic          mism_next;
  logic [2:0]    cnt_next;
  logic          last_sym;
  logic          resolving;
  logic [FW-1:0] fail_cnt_next;

  assign sym_any       = sym_valid | sym_invalid;
  assign sym_diff      = sym_invalid | (sym != code_tab[entry_cnt_reg]);
  assign mism_next     = mism_reg | sym_diff;
  assign cnt_next      = entry_cnt_reg + 3'd1;
  assign last_sym      = (cnt_next == CNT_FULL);
  assign fail_cnt_next = (fail_cnt_reg == FAIL_MAX) ? fail_cnt_reg : fail_cnt_reg + FW'(1);
  // A wrong entry parks in ENTRY with entry_cnt full for one cycle (the fail pulse cycle),
  // then resolves to IDLE or LOCKOUT; symbols during that cycle are ignored.
  assign resolving     = (state_reg == ENTRY) && (entry_cnt_reg == CNT_FULL);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      fail_cnt_reg  <= '0;
      entry_cnt_reg <= '0;
      mism_reg      <= 1'b0;
      unlocked_reg  <= 1'b0;
      lockout_reg   <= 1'b0;
      fail_reg      <= 1'b0;
    end else begin
      fail_reg <= 1'b0;
      case (state_reg)
        IDLE, ENTRY: begin
          if (resolving) begin
            entry_cnt_reg <= '0;
            mism_reg      <= 1'b0;
            timer_reg     <= (fail_cnt_reg == FAIL_MAX) ? T_LOCK : T_ENTRY;
            if (fail_cnt_reg == FAIL_MAX) begin
              state_reg   <= LOCKOUT;
              lockout_reg <= 1'b1;
            end else begin
              state_reg   <= IDLE;
            end
          end else if (sym_any) begin
            if (last_sym && !mism_next) begin
              state_reg     <= UNLOCKED;
              unlocked_reg  <= 1'b1;
              entry_cnt_reg <= '0;
              mism_reg      <= 1'b0;
              fail_cnt_reg  <= '0;
              timer_reg     <= T_UNLOCK;
            end else begin
              state_reg     <= ENTRY;
              entry_cnt_reg <= cnt_next;
              mism_reg      <= mism_next;
              timer_reg     <= T_ENTRY;
              if (last_sym) begin
                fail_reg     <= 1'b1;
                fail_cnt_reg <= fail_cnt_next;
              end
            end
          end else if (state_reg == ENTRY) begin
            if (timer_reg == '0) begin
              state_reg     <= IDLE;
              entry_cnt_reg <= '0;
              mism_reg      <= 1'b0;
              timer_reg     <= T_ENTRY;
            end else begin
              timer_reg <= timer_reg - TW'(1);
            end
          end
        end
        UNLOCKED: begin
          if (sym_any || timer_reg == '0) begin
            state_reg    <= IDLE;
            unlocked_reg <= 1'b0;
            timer_reg    <= T_ENTRY;
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end
        LOCKOUT: begin
          if (timer_reg == '0) begin
            state_reg    <= IDLE;
            lockout_reg  <= 1'b0;
            fail_cnt_reg <= '0;
            timer_reg    <= T_ENTRY;
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign unlocked  = unlocked_reg;
  assign lockout   = lockout_reg;
  assign fail      = fail_reg;
  assign entry_cnt = entry_cnt_reg;

endmodule
